// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the conditioner.
// The master side drives the raw buttons and the slave side (the
// conditioner) returns the debounced levels and event pulses.
`timescale 1ns/1ps
interface button_conditioner_if #(
    parameter int N_BUTTONS = 4
);
    logic [N_BUTTONS-1:0] button_i;   // raw board buttons, active-low
    logic [N_BUTTONS-1:0] button_o;   // debounced level, active-low
    logic [N_BUTTONS-1:0] pressed_o;  // debounced level, active-high
    logic [N_BUTTONS-1:0] press_o;    // one-cycle pulse per debounced press
    logic [N_BUTTONS-1:0] release_o;  // one-cycle pulse per debounced release
    logic [N_BUTTONS-1:0] hold_o;     // one-cycle pulse per long hold

    modport master (
        output button_i,
        input  button_o, pressed_o, press_o, release_o, hold_o
    );

    modport slave (
        input  button_i,
        output button_o, pressed_o, press_o, release_o, hold_o
    );
endinterface

// File: rtl/button_conditioner.sv
// Push-button front end for the stopwatch. Each lane synchronises its
// raw active-low button, debounces it, and derives press/release and
// long-hold pulses. Lanes share nothing but the clock and reset.
`timescale 1ns/1ps
module button_conditioner #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic                 clock,
    input  logic                 reset_n_i,
    button_conditioner_if.slave  btn
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [DW-1:0] D_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    // Hold counter: clears while released, counts up while pressed and
    // sticks at HOLD_CYCLES so the hold pulse cannot repeat within one press.
    function automatic logic [HW-1:0] hold_sat_inc(input logic pressed,
                                                   input logic [HW-1:0] hcnt);
        if (!pressed)
            return '0;
        else if (hcnt < HOLD_MAX)
            return hcnt + HW'(1);
        else
            return HOLD_MAX;
    endfunction

    logic [N_BUTTONS-1:0] pressed_v;
    logic [N_BUTTONS-1:0] press_v;
    logic [N_BUTTONS-1:0] release_v;
    logic [N_BUTTONS-1:0] hold_v;

    for (genvar n = 0; n < N_BUTTONS; n++) begin : g_lane
        logic          sync_p0;
        logic          sync_p1;
        logic          pressed;
        logic [DW-1:0] dcnt;
        logic [DW-1:0] dcnt_nxt;
        logic          pressed_nxt;
        logic          rise;
        logic          fall;
        logic [HW-1:0] hcnt;
        logic          press_q;
        logic          release_q;
        logic          hold_q;

        // Two-flop synchroniser; inverts so the lane works active-high.
        always_ff @(posedge clock or negedge reset_n_i) begin
            if (!reset_n_i) begin
                sync_p0 <= 1'b0;
                sync_p1 <= 1'b0;
            end else begin
                sync_p0 <= ~btn.button_i[n];
                sync_p1 <= sync_p0;
            end
        end

        // Debounce decision: accept a new level only after DEBOUNCE_CYCLES
        // consecutive disagreeing samples; any agreeing sample restarts.
        always_comb begin
            pressed_nxt = pressed;
            dcnt_nxt    = '0;
            rise        = 1'b0;
            fall        = 1'b0;
            if (sync_p1 != pressed) begin
                if (dcnt == D_LAST) begin
                    pressed_nxt = sync_p1;
                    rise        = sync_p1;
                    fall        = ~sync_p1;
                end else begin
                    dcnt_nxt = dcnt + DW'(1);
                end
            end
        end

        // Debounced level and its edge pulses, registered together so the
        // pulse lines up with the new level.
        always_ff @(posedge clock or negedge reset_n_i) begin
            if (!reset_n_i) begin
                pressed   <= 1'b0;
                dcnt      <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                pressed   <= pressed_nxt;
                dcnt      <= dcnt_nxt;
                press_q   <= rise;
                release_q <= fall;
            end
        end

        // Long-hold detection: pulse on the edge the counter reaches its
        // saturation value; re-arms only once the button is released.
        always_ff @(posedge clock or negedge reset_n_i) begin
            if (!reset_n_i) begin
                hcnt   <= '0;
                hold_q <= 1'b0;
            end else begin
                hcnt   <= hold_sat_inc(pressed, hcnt);
                hold_q <= pressed && (hcnt == HOLD_LAST);
            end
        end

        assign pressed_v[n] = pressed;
        assign press_v[n]   = press_q;
        assign release_v[n] = release_q;
        assign hold_v[n]    = hold_q;
    end

    assign btn.pressed_o = pressed_v;
    assign btn.button_o  = ~pressed_v;
    assign btn.press_o   = press_v;
    assign btn.release_o = release_v;
    assign btn.hold_o    = hold_v;

endmodule
